// File: rtl/prach_pkg.sv
// Shared types for the PRACH reshape scheduler: state encoding, beat record, helpers.
package prach_pkg;

  localparam int CHN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    RUN
  } sched_state_e;

  typedef struct packed {
    logic             dv;
    logic [CHN_W-1:0] chn;
    logic             sync;
  } sched_beat_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/prach_reshape_sched_if.sv
// Buffer-side and reshape-side signals of the scheduler; master = scheduler.
interface prach_reshape_sched_if #(
  parameter int NUM_CHN = 8
);
  logic [NUM_CHN-1:0]            buf_avail;
  logic [NUM_CHN-1:0]            buf_pop;
  logic                          dout_dv;
  logic [prach_pkg::CHN_W-1:0]   dout_chn;
  logic                          sync_out;

  modport master (input buf_avail, output buf_pop, output dout_dv, output dout_chn, output sync_out);
  modport slave  (output buf_avail, input buf_pop, input dout_dv, input dout_chn, input sync_out);
endinterface

// File: rtl/prach_sched_dly.sv
// DEPTH-stage delay line of scheduler beats, aligning beat metadata with buffer read data.
module prach_sched_dly
  import prach_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  sched_beat_t beat_i,
  output sched_beat_t beat_o,
  output logic        empty_o
);

  sched_beat_t      stage_q [DEPTH];
  logic [DEPTH-1:0] occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= beat_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // A stage holding only a sync marker still counts as in flight.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_occ
      assign occ[gi] = |stage_q[gi];
    end
  endgenerate

  assign beat_o  = stage_q[DEPTH-1];
  assign empty_o = ~|occ;

endmodule

// File: rtl/prach_reshape_sched.sv
// Slot-per-channel scheduler feeding the reshape datapath from per-channel buffers.
// Optional statistics counters are enabled with PRACH_SCHED_STATS_EN.
module prach_reshape_sched
  import prach_pkg::*;
#(
  parameter int NUM_CHN = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_en_i,
  input  logic [NUM_CHN-1:0]     cfg_chn_mask_i,
  input  logic                   sync_in_i,
  input  logic                   err_clr_i,
  prach_reshape_sched_if.master  bus,
  output logic                   busy_o,
  output logic [NUM_CHN-1:0]     err_uflow_o,
  output logic [15:0]            realign_cnt_o
`ifdef PRACH_SCHED_STATS_EN
  ,
  output logic [31:0]            stat_beats_o,
  output logic [31:0]            stat_frames_o
`endif
);

  localparam int                SLOT_W = $clog2(NUM_CHN);
  localparam logic [SLOT_W-1:0] LAST   = SLOT_W'(NUM_CHN - 1);

  sched_state_e       state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d, cur_slot;
  logic [NUM_CHN-1:0] mask_q, mask_d, eff_mask;
  logic [NUM_CHN-1:0] uflow_q, uflow_d;
  logic [15:0]        realign_q, realign_d;
  logic               issue, realign_hit, pop_any, uflow_hit;
  sched_beat_t        beat_in, beat_out;
  logic               dly_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      mask_q    <= '0;
      uflow_q   <= '0;
      realign_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      mask_q    <= mask_d;
      uflow_q   <= uflow_d;
      realign_q <= realign_d;
    end
  end

  // cur_slot is the slot issued this cycle; a sync can force it to 0 before it is used.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    mask_d      = mask_q;
    issue       = 1'b0;
    cur_slot    = slot_q;
    realign_hit = 1'b0;
    unique case (state_q)
      IDLE: if (cfg_en_i) state_d = WAIT_SYNC;
      WAIT_SYNC: begin
        if (!cfg_en_i) begin
          state_d = IDLE;
        end else if (sync_in_i) begin
          state_d  = RUN;
          issue    = 1'b1;
          cur_slot = '0;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (sync_in_i && slot_q != LAST) begin
          cur_slot    = '0;
          realign_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (cur_slot == LAST) begin
        slot_d = '0;
        if (!cfg_en_i) state_d = IDLE;
      end else begin
        slot_d = cur_slot + SLOT_W'(1);
      end
      if (cur_slot == '0) mask_d = cfg_chn_mask_i;
    end
  end

  // Slot 0 uses the mask being latched in the same cycle.
  assign eff_mask  = (cur_slot == '0) ? cfg_chn_mask_i : mask_q;
  assign pop_any   = issue & eff_mask[cur_slot] & bus.buf_avail[cur_slot];
  assign uflow_hit = issue & eff_mask[cur_slot] & ~bus.buf_avail[cur_slot];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHN; gi++) begin : g_chn
      assign bus.buf_pop[gi] = pop_any && (cur_slot == SLOT_W'(gi));
      assign uflow_d[gi]     = (uflow_hit && (cur_slot == SLOT_W'(gi))) | (uflow_q[gi] & ~err_clr_i);
    end
  endgenerate

  assign realign_d = realign_hit ? sat_inc16(realign_q) : (err_clr_i ? 16'd0 : realign_q);

  assign beat_in.dv   = pop_any;
  assign beat_in.chn  = pop_any ? CHN_W'(cur_slot) : '0;
  assign beat_in.sync = issue && (cur_slot == '0);

  prach_sched_dly #(.DEPTH(RD_LAT)) u_dly (
    .clk     (clk),
    .rst     (rst),
    .beat_i  (beat_in),
    .beat_o  (beat_out),
    .empty_o (dly_empty)
  );

  assign bus.dout_dv  = beat_out.dv;
  assign bus.dout_chn = beat_out.chn;
  assign bus.sync_out = beat_out.sync;
  assign busy_o        = (state_q != IDLE) | ~dly_empty;
  assign err_uflow_o   = uflow_q;
  assign realign_cnt_o = realign_q;

`ifdef PRACH_SCHED_STATS_EN
  logic [31:0] beats_q, frames_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q  <= '0;
      frames_q <= '0;
    end else begin
      if (beat_out.dv)    beats_q <= beats_q + 32'd1;
      else if (err_clr_i) beats_q <= '0;
      if (beat_out.sync)  frames_q <= frames_q + 32'd1;
      else if (err_clr_i) frames_q <= '0;
    end
  end

  assign stat_beats_o  = beats_q;
  assign stat_frames_o = frames_q;
`endif

endmodule
